// File: rtl/psum_drain.sv
// psum_drain: captures final accumulator sums, requantizes them to OUT_WIDTH
// (round, optional ReLU, saturate) and queues them for the ofmap writer.
module psum_drain #(
    parameter int ACC_WIDTH   = 35,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ACC_WIDTH-1:0]       acc_data,
    input  logic                       acc_done,
    input  logic [SHIFT_WIDTH-1:0]     shift,
    input  logic                       relu_en,
    input  logic                       clr_flags,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       sat_seen
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic signed [ACC_WIDTH:0] ONE  = {{ACC_WIDTH{1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MINV = {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH-1:0]      s1_data;
    logic [SHIFT_WIDTH-1:0]    s1_shift;
    logic                      s1_relu, s1_valid;
    logic signed [ACC_WIDTH:0] rnd, shr, rq;
    logic                      sat_hi, sat_lo, full, pop, push;
    logic [OUT_WIDTH-1:0]      q;
    logic [OUT_WIDTH-1:0]      mem [DEPTH];
    logic [AW-1:0]             wp, rp;
    logic [CW-1:0]             cnt_n;

    // One extra bit of headroom keeps the rounding add from overflowing
    always_comb begin
        rnd    = (s1_shift == '0) ? '0 : ONE << (s1_shift - SHIFT_WIDTH'(1));
        shr    = ($signed({s1_data[ACC_WIDTH-1], s1_data}) + rnd) >>> s1_shift;
        rq     = (s1_relu && shr[ACC_WIDTH]) ? '0 : shr;
        sat_hi = rq > MAXV;
        sat_lo = rq < MINV;
        q      = sat_hi ? MAXV[OUT_WIDTH-1:0] : sat_lo ? MINV[OUT_WIDTH-1:0] : rq[OUT_WIDTH-1:0];
        full   = count == CW'(DEPTH);
        pop    = out_valid & out_ready;
        push   = s1_valid & (~full | pop);
        cnt_n  = count + CW'(push) - CW'(pop);
    end

    assign out_data = out_valid ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            sat_seen  <= 1'b0;
        end else begin
            s1_valid <= acc_done;
            if (acc_done) begin
                s1_data  <= acc_data;
                s1_shift <= shift;
                s1_relu  <= relu_en;
            end
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count     <= cnt_n;
            out_valid <= cnt_n != '0;
            overflow  <= (s1_valid & full & ~pop) | (overflow & ~clr_flags);
            sat_seen  <= (s1_valid & (sat_hi | sat_lo)) | (sat_seen & ~clr_flags);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) mem[wp] <= q;
    end
endmodule
